rat_path_recorder: RTL and testbench
====================================

Name: rat_path_recorder

Overview:
- Downstream of the intelligent-rat maze solver.
- Records the solver's 2-bit move stream as a LIFO path, with push for forward steps and pop for backtracking.
- When `run` rises, replays the final solution path from first move to last over a valid/ready interface to the actuator/display stage.
- Also reports completion and overflow.

Parameters:
- DEPTH, 256, maximum number of stored moves (power of two).
- AW, 8, address/count width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  store move_in on top of path (solver stepped forward).
- pop  input  1  discard top move (solver backtracked).
- move_in  input  2  move code from solver (00 up, 01 right, 10 left, 11 down; opaque to this block).
- run  input  1  level; its rising edge starts replay.
- clear  input  1  synchronous clear of path and status, returns to RECORD.
- out_ready  input  1  downstream accepts move_out this cycle.
- out_valid  output  1  move_out holds a valid replay move.
- move_out  output  2  replayed move code.
- replay_done  output  1  replay finished; held until clear or rst.
- overflow  output  1  sticky; a push was attempted while full.
- empty  output  1  count == 0.
- count  output  AW+1  number of stored moves (0..DEPTH).

Behaviour:
- Reset (async, rst=1):
  - State = RECORD; count=0, rd_ptr=0, run edge register=0.
  - out_valid=0, move_out=00, replay_done=0, overflow=0, empty=1.
  - Memory contents are don't-care.
- Storage: DEPTH x 2 register array, synchronous write, combinational read at rd_ptr. move_out is registered.
- run edge detect: run_q registered each cycle; run_rise = run & ~run_q. A held `run` triggers once only.
- State RECORD:
  - push only, count<DEPTH: mem[count]<=move_in, count++.
  - push only, count==DEPTH: no write; overflow<=1.
  - pop only, count>0: count--.
  - pop only, count==0: ignored, no underflow.
  - push & pop together, count>0: replace top; mem[count-1]<=move_in, count unchanged.
  - push & pop together, count==0: treated as push.
  - run_rise, count==0: go to DONE; replay_done=1 next cycle; out_valid stays 0.
  - run_rise, count>0: go to REPLAY with rd_ptr=0. out_valid=1 and move_out=mem[0] in the next cycle (1-cycle latency).
  - run_rise has priority over push/pop in the same cycle; the push/pop is dropped.
- State REPLAY:
  - push/pop ignored.
  - out_valid=1 and move_out stable until out_valid & out_ready.
  - On handshake with rd_ptr<count-1: rd_ptr++; move_out=mem[rd_ptr+1] next cycle (back-to-back, one move per cycle when ready is held high).
  - On handshake with rd_ptr==count-1: go to DONE; out_valid=0 and replay_done=1 next cycle.
  - count is unchanged by replay.
- State DONE:
  - out_valid=0; replay_done=1.
  - push/pop/run ignored.
- clear (any state, synchronous): state=RECORD, count=0, rd_ptr=0, out_valid=0, replay_done=0, overflow=0.
- clear has priority over all other inputs in that cycle.
- rst asserted at any time (including mid-REPLAY) forces reset values immediately. After release, the block is in RECORD with an empty path.
- empty = (count==0), combinational from count.

Test Plan:
- Push 01,01,11 in 3 cycles, then run rising with out_ready=1 -> next 3 cycles move_out=01,01,11 with out_valid=1, then out_valid=0, replay_done=1, count stays 3.
- Push 01,11,10, pop, push 00 -> replay gives 01,11,00.
- Push 10, then push+pop with move_in=11 -> count=1; replay gives 11 only.
- DEPTH=4: 5 pushes -> count=4, overflow=1 and sticky; replay gives the first 4 moves; clear -> overflow=0, count=0.
- Backpressure: replay 2 moves with out_ready low 3 cycles -> move_out holds first move; each move is accepted exactly once.
- run with empty path -> replay_done=1 one cycle later, out_valid never 1.
- rst pulsed mid-replay -> out_valid=0, count=0, replay_done=0 immediately.
- run held high 50 cycles -> exactly one replay.

Source files
------------

// File: rtl/rat_path_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : rat_path_recorder
//  Description : Records the maze solver's 2-bit move stream as a LIFO path.
//                A push stores a forward step, a pop discards the top step
//                (backtracking), and push+pop together replaces the top step.
//                A rising edge on run replays the stored path, first move to
//                last, over a valid/ready interface. Completion and a sticky
//                overflow flag are also reported.
//
//  Ports       : clk          system clock, rising edge
//                rst          asynchronous active-high reset
//                push         store move_in on top of the path
//                pop          discard the top move
//                move_in[1:0] move code from the solver (opaque here)
//                run          level; its rising edge starts replay
//                clear        synchronous clear of path and status
//                out_ready    downstream accepts move_out this cycle
//                out_valid    move_out holds a valid replay move
//                move_out[1:0] replayed move code (registered)
//                replay_done  replay finished, held until clear or rst
//                overflow     sticky, a push was attempted while full
//                empty        count == 0
//                count[AW:0]  number of stored moves (0..DEPTH)
//
//  Revision    : 1.0  initial release
// ============================================================================
module rat_path_recorder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    move_in,
    input  logic          run,
    input  logic          clear,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [1:0]    move_out,
    output logic          replay_done,
    output logic          overflow,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [1:0]  c_record = 2'd0;
    localparam logic [1:0]  c_replay = 2'd1;
    localparam logic [1:0]  c_done   = 2'd2;
    localparam logic [AW:0] c_full   = (AW+1)'(DEPTH);

    // Path storage; contents are don't-care after reset or clear.
    logic [1:0]    r_mem [DEPTH];

    logic [1:0]    r_state;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_rd_ptr;
    logic          r_run_q;
    logic          r_out_valid;
    logic [1:0]    r_move_out;
    logic          r_replay_done;
    logic          r_overflow;

    logic [1:0]    w_state;
    logic [AW:0]   w_count;
    logic [AW-1:0] w_rd_ptr;
    logic          w_out_valid;
    logic [1:0]    w_move_out;
    logic          w_replay_done;
    logic          w_overflow;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic          w_run_rise;
    logic [AW:0]   w_count_m1;
    logic [AW-1:0] w_rd_next;

    assign w_run_rise = run & ~r_run_q;
    assign w_count_m1 = r_count - 1'b1;
    assign w_rd_next  = r_rd_ptr + 1'b1;

    // ------------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state       = r_state;
        w_count       = r_count;
        w_rd_ptr      = r_rd_ptr;
        w_out_valid   = r_out_valid;
        w_move_out    = r_move_out;
        w_replay_done = r_replay_done;
        w_overflow    = r_overflow;
        w_we          = 1'b0;
        w_waddr       = '0;

        case (r_state)
            c_record: begin
                // A run edge wins over any simultaneous push/pop.
                if (w_run_rise) begin
                    if (r_count == '0) begin
                        w_state       = c_done;
                        w_replay_done = 1'b1;
                    end else begin
                        w_state     = c_replay;
                        w_rd_ptr    = '0;
                        w_out_valid = 1'b1;
                        w_move_out  = r_mem[0];
                    end
                end else begin
                    case ({push, pop})
                        2'b10: begin
                            if (r_count != c_full) begin
                                w_we    = 1'b1;
                                w_waddr = r_count[AW-1:0];
                                w_count = r_count + 1'b1;
                            end else begin
                                w_overflow = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (r_count != '0) begin
                                w_count = w_count_m1;
                            end
                        end
                        2'b11: begin
                            // Replace the top move; on an empty path this is a plain push.
                            w_we = 1'b1;
                            if (r_count != '0) begin
                                w_waddr = w_count_m1[AW-1:0];
                            end else begin
                                w_waddr = '0;
                                w_count = r_count + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            c_replay: begin
                if (r_out_valid && out_ready) begin
                    if ({1'b0, r_rd_ptr} == w_count_m1) begin
                        w_state       = c_done;
                        w_out_valid   = 1'b0;
                        w_replay_done = 1'b1;
                    end else begin
                        w_rd_ptr   = w_rd_next;
                        w_move_out = r_mem[w_rd_next];
                    end
                end
            end

            c_done: begin
                w_out_valid   = 1'b0;
                w_replay_done = 1'b1;
            end

            default: begin
                w_state = c_record;
            end
        endcase

        if (clear) begin
            w_state       = c_record;
            w_count       = '0;
            w_rd_ptr      = '0;
            w_out_valid   = 1'b0;
            w_replay_done = 1'b0;
            w_overflow    = 1'b0;
            w_we          = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_record;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_run_q       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_move_out    <= 2'b00;
            r_replay_done <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_count       <= w_count;
            r_rd_ptr      <= w_rd_ptr;
            r_run_q       <= run;
            r_out_valid   <= w_out_valid;
            r_move_out    <= w_move_out;
            r_replay_done <= w_replay_done;
            r_overflow    <= w_overflow;
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= move_in;
        end
    end

    assign out_valid   = r_out_valid;
    assign move_out    = r_move_out;
    assign replay_done = r_replay_done;
    assign overflow    = r_overflow;
    assign count       = r_count;
    assign empty       = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_rat_path_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rat_path_recorder
//  Description : Directed self-checking bench for rat_path_recorder, built
//                with a 4-entry path so the full/overflow corner is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rat_path_recorder;

    localparam int c_depth = 4;
    localparam int c_aw    = 2;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic [1:0]    move_in;
    logic          run;
    logic          clear;
    logic          out_ready;
    logic          out_valid;
    logic [1:0]    move_out;
    logic          replay_done;
    logic          overflow;
    logic          empty;
    logic [c_aw:0] count;

    int n_chk;
    int n_pass;
    int hs_cnt;
    int hs_base;

    rat_path_recorder #(
        .DEPTH (c_depth),
        .AW    (c_aw)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .move_in     (move_in),
        .run         (run),
        .clear       (clear),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .move_out    (move_out),
        .replay_done (replay_done),
        .overflow    (overflow),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every accepted replay move.
    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt = hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] m);
        push = 1'b1; move_in = m;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", 32'(count), 0);
        chk("clear_done", 32'(replay_done), 0);
        chk("clear_ovf", 32'(overflow), 0);
    endtask

    // Replay with ready held high; exp holds moves, first move in bits [1:0].
    task automatic run_replay(input string tag, input int n, input logic [7:0] exp);
        logic [7:0] e;
        e = exp;
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_move"}, 32'(move_out), 32'(e[2*i +: 2]));
            tick();
        end
        chk({tag, "_end_valid"}, 32'(out_valid), 0);
        chk({tag, "_end_done"}, 32'(replay_done), 1);
        chk({tag, "_count_kept"}, 32'(count), 32'(n));
        run = 1'b0;
        tick();
        do_clear();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; hs_cnt = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; move_in = 2'b00;
        run = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #23 rst = 1'b0;
        #1;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_move", 32'(move_out), 0);
        chk("rst_done", 32'(replay_done), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Pop on empty path is ignored
        do_pop();
        chk("pop_empty", 32'(count), 0);

        // Basic record and replay
        do_push(2'b01); do_push(2'b01); do_push(2'b11);
        chk("basic_count", 32'(count), 3);
        chk("basic_empty", 32'(empty), 0);
        run_replay("basic", 3, 8'b00_11_01_01);

        // Backtracking
        do_push(2'b01); do_push(2'b11); do_push(2'b10); do_pop(); do_push(2'b00);
        chk("bt_count", 32'(count), 3);
        run_replay("bt", 3, 8'b00_00_11_01);

        // Replace top
        do_push(2'b10);
        push = 1'b1; pop = 1'b1; move_in = 2'b11;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("repl_count", 32'(count), 1);
        run_replay("repl", 1, 8'b00_00_00_11);

        // Push+pop on empty path acts as push
        push = 1'b1; pop = 1'b1; move_in = 2'b10;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("pp_empty_count", 32'(count), 1);
        run_replay("pp_empty", 1, 8'b00_00_00_10);

        // Overflow
        do_push(2'b00); do_push(2'b01); do_push(2'b10); do_push(2'b11);
        chk("full_ovf_before", 32'(overflow), 0);
        do_push(2'b01);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        tick(); tick();
        chk("ovf_sticky", 32'(overflow), 1);
        run_replay("ovf", 4, 8'b11_10_01_00);

        // Backpressure
        do_push(2'b10); do_push(2'b01);
        hs_base = hs_cnt;
        out_ready = 1'b0;
        run = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_move", 32'(move_out), 2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 32'(out_valid), 1);
        chk("bp_second_move", 32'(move_out), 1);
        tick();
        chk("bp_end_valid", 32'(out_valid), 0);
        chk("bp_end_done", 32'(replay_done), 1);
        chk("bp_accepts", 32'(hs_cnt - hs_base), 2);
        run = 1'b0;
        do_clear();

        // Run with empty path
        run = 1'b1;
        tick();
        chk("er_done", 32'(replay_done), 1);
        chk("er_valid", 32'(out_valid), 0);
        tick(); tick();
        chk("er_valid_later", 32'(out_valid), 0);
        chk("er_done_held", 32'(replay_done), 1);
        run = 1'b0;
        do_clear();

        // Asynchronous reset mid-replay
        do_push(2'b01); do_push(2'b10); do_push(2'b11);
        out_ready = 1'b1;
        run = 1'b1;
        tick();
        chk("ar_valid_before", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_done", 32'(replay_done), 0);
        run = 1'b0;
        #1 rst = 1'b0;
        tick();
        chk("ar_after_empty", 32'(empty), 1);
        do_push(2'b11);
        chk("ar_record", 32'(count), 1);
        do_clear();

        // Run held high for many cycles replays once
        do_push(2'b11); do_push(2'b00);
        hs_base = hs_cnt;
        out_ready = 1'b1;
        run = 1'b1;
        repeat (50) tick();
        chk("hold_accepts", 32'(hs_cnt - hs_base), 2);
        chk("hold_done", 32'(replay_done), 1);
        chk("hold_valid", 32'(out_valid), 0);
        run = 1'b0;
        do_clear();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
